hub75_bcm_scan_controller: RTL

//  Parametrised HUB75 panel driver: scans WIDTH x HEIGHT panel as two halves (HEIGHT/2 scan rows),

---
 rtl/hub75_bcm_scan_controller.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/hub75_bcm_scan_controller.sv
// hub75_bcm_scan_controller: HUB75 scan driver with binary-coded-modulation bit-plane display.
// Define BRIGHTNESS_EN to add the brightness port that trims OE_N low time within each plane.
module hub75_bcm_scan_controller #(
  parameter int SCREEN_WIDTH = 32,
  parameter int SCREEN_DEPTH = 16,
  parameter int COLOR_DEPTH  = 4,
  parameter int OUTPUT_BASE  = 8,
  localparam int SCAN_ROWS   = SCREEN_DEPTH / 2,
  localparam int ADDR_W      = $clog2(SCREEN_WIDTH * SCAN_ROWS)
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     enable,
  output logic [ADDR_W-1:0]        fb_addr,
  input  logic [6*COLOR_DEPTH-1:0] fb_rdata,
  output logic                     R1_data,
  output logic                     G1_data,
  output logic                     B1_data,
  output logic                     R2_data,
  output logic                     G2_data,
  output logic                     B2_data,
  output logic                     A,
  output logic                     B,
  output logic                     C,
  output logic                     D,
  output logic                     E,
  output logic                     clk_out,
  output logic                     LAT,
  output logic                     OE_N,
  output logic                     done
`ifdef BRIGHTNESS_EN
  ,input logic [7:0]               brightness
`endif
);
  localparam int CLW = $clog2(SCREEN_WIDTH);
  localparam int PW  = COLOR_DEPTH > 1 ? $clog2(COLOR_DEPTH) : 1;
  localparam int CW  = $clog2((OUTPUT_BASE << (COLOR_DEPTH - 1)) + 1);
  typedef enum logic [2:0] {IDLE, PRIME, SHIFT, LATCH, DISPLAY} state_t;
  state_t state_q, state_d;
  logic phase_q, phase_d;
  logic [CLW-1:0] col_q, col_d;
  logic [PW-1:0] plane_q, plane_d;
  logic [4:0] row_q, row_d, addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d, len, on_len;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [5:0] rgb_q, rgb_d;
  logic clk_out_q, clk_out_d, lat_q, lat_d, oe_n_q, oe_n_d, done_q, done_d;
  assign len = CW'(OUTPUT_BASE << plane_q);
`ifdef BRIGHTNESS_EN
  logic [7:0] bright_q, br;
  logic [CW+8:0] prod;
  // Brightness is taken straight from the port during LATCH so the first DISPLAY cycle already uses it.
  assign br = state_q == LATCH ? brightness : bright_q;
  assign prod = (CW+9)'(len) * (CW+9)'(br) + (CW+9)'(len);
  assign on_len = CW'(prod >> 8);
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) bright_q <= '0;
    else bright_q <= br;
`else
  assign on_len = len;
`endif
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    col_d = col_q;
    plane_d = plane_q;
    row_d = row_q;
    cnt_d = cnt_q;
    rgb_d = rgb_q;
    addr_d = addr_q;
    fb_addr_d = fb_addr_q;
    case (state_q)
      IDLE: state_d = enable ? PRIME : IDLE;
      PRIME: begin
        state_d = enable ? SHIFT : IDLE;
        col_d = '0;
        phase_d = 1'b0;
      end
      SHIFT: begin
        phase_d = !phase_q;
        if (!phase_q) begin
          rgb_d = {fb_rdata[5*COLOR_DEPTH + plane_q], fb_rdata[4*COLOR_DEPTH + plane_q],
                   fb_rdata[3*COLOR_DEPTH + plane_q], fb_rdata[2*COLOR_DEPTH + plane_q],
                   fb_rdata[COLOR_DEPTH + plane_q], fb_rdata[plane_q]};
          fb_addr_d = col_q == CLW'(SCREEN_WIDTH - 1) ? fb_addr_q : fb_addr_q + 1'b1;
        end else if (col_q == CLW'(SCREEN_WIDTH - 1)) begin
          state_d = LATCH;
          addr_d = row_q;
        end else col_d = col_q + 1'b1;
      end
      LATCH: begin
        state_d = DISPLAY;
        cnt_d = '0;
      end
      DISPLAY: begin
        if (cnt_q == len - 1'b1) begin
          state_d = PRIME;
          plane_d = plane_q == PW'(COLOR_DEPTH - 1) ? '0 : plane_q + 1'b1;
          if (plane_q == PW'(COLOR_DEPTH - 1))
            row_d = row_q == 5'(SCAN_ROWS - 1) ? '0 : row_q + 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // The first pixel address is issued on entry to PRIME so its data is ready at the first shift phase.
    if (state_d == PRIME) fb_addr_d = ADDR_W'(int'(row_d) * SCREEN_WIDTH);
    clk_out_d = state_d == SHIFT && phase_d;
    lat_d = state_d == LATCH;
    oe_n_d = !(state_d == DISPLAY && cnt_d < on_len);
    done_d = state_d == DISPLAY && cnt_d == len - 1'b1 &&
             plane_q == PW'(COLOR_DEPTH - 1) && row_q == 5'(SCAN_ROWS - 1);
  end
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      state_q <= IDLE;
      phase_q <= 1'b0;
      col_q <= '0;
      plane_q <= '0;
      row_q <= '0;
      cnt_q <= '0;
      rgb_q <= '0;
      addr_q <= '0;
      fb_addr_q <= '0;
      clk_out_q <= 1'b0;
      lat_q <= 1'b0;
      oe_n_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      col_q <= col_d;
      plane_q <= plane_d;
      row_q <= row_d;
      cnt_q <= cnt_d;
      rgb_q <= rgb_d;
      addr_q <= addr_d;
      fb_addr_q <= fb_addr_d;
      clk_out_q <= clk_out_d;
      lat_q <= lat_d;
      oe_n_q <= oe_n_d;
      done_q <= done_d;
    end
  assign {R2_data, G2_data, B2_data, R1_data, G1_data, B1_data} = rgb_q;
  assign {E, D, C, B, A} = addr_q;
  assign fb_addr = fb_addr_q;
  assign clk_out = clk_out_q;
  assign LAT = lat_q;
  assign OE_N = oe_n_q;
  assign done = done_q;
endmodule
